veri_risc_core: RTL and testbench

//  Parametrised multi-cycle VeriRISC accumulator core; successor to the fixed 8-phase top level.
//  A state machine replaces the free-running phase counter. Memory is external, behind a
//    req/ack handshake that supports any number of wait states.

---
 rtl/veri_risc_pkg.sv | 23 ++
 rtl/veri_risc_alu.sv | 24 ++
 rtl/veri_risc_core.sv | 151 +++++++++++++++
 tb/tb_veri_risc_core.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/veri_risc_pkg.sv
// Shared VeriRISC definitions: opcode encodings and control-state encodings.
package veri_risc_pkg;

  typedef enum logic [2:0] {
    OP_HLT = 3'd0,
    OP_SKZ = 3'd1,
    OP_ADD = 3'd2,
    OP_AND = 3'd3,
    OP_XOR = 3'd4,
    OP_LDA = 3'd5,
    OP_STO = 3'd6,
    OP_JMP = 3'd7
  } opcode_t;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_READ   = 3'd2,
    S_WRITE  = 3'd3,
    S_HALT   = 3'd4
  } state_t;

endpackage

// File: rtl/veri_risc_alu.sv
// Combinational accumulator function selected by the current opcode.
module veri_risc_alu
  import veri_risc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  opcode_t               op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] y
);

  always_comb begin
    y = a;
    case (op)
      OP_ADD:  y = a + b;
      OP_AND:  y = a & b;
      OP_XOR:  y = a ^ b;
      OP_LDA:  y = b;
      default: y = a;
    endcase
  end

endmodule

// File: rtl/veri_risc_core.sv
// Multi-cycle VeriRISC accumulator core with a req/ack memory port,
// resume-from-halt and an instructions-retired counter.
module veri_risc_core
  import veri_risc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ack,
  input  logic                  resume,
  output logic                  halt,
  output logic                  zero,
  output logic [CNT_WIDTH-1:0]  retired
);

  state_t                state;
  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] pc_inc;
  logic [ADDR_WIDTH-1:0] pc_skz;
  logic [ADDR_WIDTH-1:0] operand;
  logic [DATA_WIDTH-1:0] ir;
  logic [DATA_WIDTH-1:0] ac;
  logic [DATA_WIDTH-1:0] alu_y;
  logic [CNT_WIDTH-1:0]  retired_inc;
  opcode_t               opcode;

  assign opcode      = opcode_t'(ir[DATA_WIDTH-1 -: 3]);
  assign operand     = ir[ADDR_WIDTH-1:0];
  assign pc_inc      = pc + ADDR_WIDTH'(1);
  assign pc_skz      = zero ? pc_inc : pc;
  assign zero        = (ac == '0);
  assign retired_inc = retired + CNT_WIDTH'(1);

  veri_risc_alu #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_alu (
    .op(opcode),
    .a (ac),
    .b (mem_rdata),
    .y (alu_y)
  );

  // Memory-port outputs are registered and loaded on entry to each state,
  // so they depend on state alone; reset drops mem_req for one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_FETCH;
      pc        <= '0;
      ir        <= '0;
      ac        <= '0;
      retired   <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      halt      <= 1'b0;
    end else begin
      case (state)
        S_FETCH: begin
          if (!mem_req) begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= pc;
          end else if (mem_ack) begin
            ir      <= mem_rdata;
            pc      <= pc_inc;
            mem_req <= 1'b0;
            state   <= S_DECODE;
          end
        end
        S_DECODE: begin
          case (opcode)
            OP_HLT: begin
              halt    <= 1'b1;
              retired <= retired_inc;
              state   <= S_HALT;
            end
            OP_SKZ: begin
              pc       <= pc_skz;
              mem_req  <= 1'b1;
              mem_we   <= 1'b0;
              mem_addr <= pc_skz;
              retired  <= retired_inc;
              state    <= S_FETCH;
            end
            OP_JMP: begin
              pc       <= operand;
              mem_req  <= 1'b1;
              mem_we   <= 1'b0;
              mem_addr <= operand;
              retired  <= retired_inc;
              state    <= S_FETCH;
            end
            OP_STO: begin
              mem_req   <= 1'b1;
              mem_we    <= 1'b1;
              mem_addr  <= operand;
              mem_wdata <= ac;
              state     <= S_WRITE;
            end
            default: begin
              mem_req  <= 1'b1;
              mem_we   <= 1'b0;
              mem_addr <= operand;
              state    <= S_READ;
            end
          endcase
        end
        S_READ: begin
          if (mem_ack) begin
            ac       <= alu_y;
            mem_addr <= pc;
            retired  <= retired_inc;
            state    <= S_FETCH;
          end
        end
        S_WRITE: begin
          if (mem_ack) begin
            mem_we   <= 1'b0;
            mem_addr <= pc;
            retired  <= retired_inc;
            state    <= S_FETCH;
          end
        end
        S_HALT: begin
          if (resume) begin
            halt     <= 1'b0;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= pc;
            state    <= S_FETCH;
          end
        end
        default: begin
          mem_req <= 1'b0;
          halt    <= 1'b0;
          state   <= S_FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_veri_risc_core.sv
// Directed bench for veri_risc_core with a req/ack memory model of configurable wait states.
module tb_veri_risc_core;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req;
  logic        mem_we;
  logic [4:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_ack;
  logic        resume = 1'b0;
  logic        halt;
  logic        zero;
  logic [15:0] retired;

  logic [7:0]  prog [32];
  logic [7:0]  wr_mem [32];
  logic [31:0] wr_valid = '0;
  logic [4:0]  acc_log [$];
  int          delay = 0;
  int          cnt = 0;
  logic        ack_force = 1'b0;
  logic        mon_en = 1'b0;
  logic        prev_req = 1'b0;
  logic        prev_ack = 1'b0;
  logic        prev_we = 1'b0;
  logic [4:0]  prev_addr = '0;
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  veri_risc_core #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(5),
    .CNT_WIDTH (16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ack  (mem_ack),
    .resume   (resume),
    .halt     (halt),
    .zero     (zero),
    .retired  (retired)
  );

  // Memory model: ack after 'delay' wait states; stores shadow the program image.
  assign mem_ack   = ack_force | (mem_req && cnt == delay);
  assign mem_rdata = wr_valid[mem_addr] ? wr_mem[mem_addr] : prog[mem_addr];

  always @(posedge clk) begin
    if (rst || !mem_req || mem_ack) cnt <= 0;
    else                            cnt <= cnt + 1;
    if (rst) begin
      wr_valid <= '0;
      acc_log.delete();
    end else if (mem_req && mem_ack) begin
      acc_log.push_back(mem_addr);
      if (mem_we) begin
        wr_mem[mem_addr]   <= mem_wdata;
        wr_valid[mem_addr] <= 1'b1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Address/direction must hold through every wait state.
  always @(negedge clk) begin
    if (mon_en && mem_req && prev_req && !prev_ack) begin
      check("addr_stable", {27'd0, mem_addr}, {27'd0, prev_addr});
      check("we_stable", {31'd0, mem_we}, {31'd0, prev_we});
    end
    prev_req  <= mem_req;
    prev_ack  <= mem_ack;
    prev_we   <= mem_we;
    prev_addr <= mem_addr;
  end

  function automatic logic [7:0] mem_rd(input int a);
    return wr_valid[a] ? wr_mem[a] : prog[a];
  endfunction

  task automatic clear_prog();
    for (int i = 0; i < 32; i++) prog[i] = 8'h00;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst    = 1'b1;
    resume = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_halt", {31'd0, halt}, 32'd0);
    check("rst_zero", {31'd0, zero}, 32'd1);
    check("rst_retired", {16'd0, retired}, 32'd0);
    check("rst_req", {31'd0, mem_req}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("start_req", {31'd0, mem_req}, 32'd1);
    check("start_we", {31'd0, mem_we}, 32'd0);
    check("start_addr", {27'd0, mem_addr}, 32'd0);
  endtask

  // Cycles counted from the first requesting cycle to the first cycle with halt high.
  task automatic wait_halt(output int cyc);
    cyc = 0;
    while (!halt && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    check("halt_reached", {31'd0, halt}, 32'd1);
  endtask

  task automatic wait_log(input int n);
    int c;
    c = 0;
    while (acc_log.size() < n && c < 400) begin
      @(negedge clk);
      c++;
    end
    check("log_len_reached", acc_log.size(), n);
  endtask

  task automatic run_prog_basic(input int d, input int exp_cyc);
    int cyc;
    clear_prog();
    prog[0]  = 8'hAA;  // LDA 10
    prog[1]  = 8'h4B;  // ADD 11
    prog[2]  = 8'hCC;  // STO 12
    prog[3]  = 8'h00;  // HLT
    prog[10] = 8'h0F;
    prog[11] = 8'h01;
    delay    = d;
    do_reset();
    wait_halt(cyc);
    check("prog_cycles", cyc, exp_cyc);
    check("prog_retired", {16'd0, retired}, 32'd4);
    check("prog_mem12", {24'd0, mem_rd(12)}, 32'h10);
    check("prog_zero", {31'd0, zero}, 32'd0);
  endtask

  initial begin
    int cyc;
    int c;

    // Basic program, zero-wait: LDA3 + ADD3 + STO3 + HLT2 = 11 cycles.
    run_prog_basic(0, 11);

    // Three wait states on each of 7 accesses: 11 + 21 = 32 cycles.
    mon_en = 1'b1;
    run_prog_basic(3, 32);
    mon_en = 1'b0;

    // SKZ with ac==0 skips the JMP at 1.
    clear_prog();
    prog[0] = 8'h20; prog[1] = 8'hE5; prog[2] = 8'h00; prog[5] = 8'h00;
    delay = 0;
    do_reset();
    wait_halt(cyc);
    check("skz_taken_addr", {27'd0, acc_log[1]}, 32'd2);
    check("skz_taken_ret", {16'd0, retired}, 32'd2);

    // SKZ with ac==7 falls through to JMP 5.
    clear_prog();
    prog[0] = 8'hB4; prog[20] = 8'h07; prog[1] = 8'h20; prog[2] = 8'hE5;
    prog[3] = 8'h00; prog[5] = 8'h00;
    do_reset();
    wait_halt(cyc);
    check("skz_fall_addr", {27'd0, acc_log[3]}, 32'd2);
    check("jmp_target", {27'd0, acc_log[4]}, 32'd5);
    check("skz_fall_ret", {16'd0, retired}, 32'd4);

    // JMP 31 then XOR at 31: next fetch wraps to 0.
    clear_prog();
    prog[0] = 8'hFF; prog[31] = 8'h9D; prog[29] = 8'h00;
    do_reset();
    wait_log(4);
    check("jmp31_addr", {27'd0, acc_log[1]}, 32'd31);
    check("pc_wrap", {27'd0, acc_log[3]}, 32'd0);

    // SKZ at 31 with ac==0: double increment wraps to 1.
    clear_prog();
    prog[0] = 8'hFF; prog[31] = 8'h20; prog[1] = 8'h00;
    do_reset();
    wait_halt(cyc);
    check("skz_wrap", {27'd0, acc_log[2]}, 32'd1);
    check("skz_wrap_ret", {16'd0, retired}, 32'd3);

    // HLT at 3, stray acks while halted, then resume continues at 4.
    clear_prog();
    prog[0] = 8'h20; prog[2] = 8'hE3; prog[3] = 8'h00; prog[4] = 8'h00;
    do_reset();
    wait_halt(cyc);
    check("hlt_ret", {16'd0, retired}, 32'd3);
    ack_force = 1'b1;
    repeat (3) @(negedge clk);
    ack_force = 1'b0;
    repeat (7) @(negedge clk);
    check("halt_hold", {31'd0, halt}, 32'd1);
    check("halt_no_req", {31'd0, mem_req}, 32'd0);
    check("halt_ack_ignored", {16'd0, retired}, 32'd3);
    resume = 1'b1;
    @(negedge clk);
    resume = 1'b0;
    check("resume_halt", {31'd0, halt}, 32'd0);
    check("resume_req", {31'd0, mem_req}, 32'd1);
    check("resume_addr", {27'd0, mem_addr}, 32'd4);
    wait_halt(cyc);
    check("resume_ret", {16'd0, retired}, 32'd4);

    // resume held high across HLT entry: HALT lasts exactly one cycle.
    clear_prog();
    do_reset();
    resume = 1'b1;
    wait_halt(cyc);
    check("held_halt_cyc", cyc, 2);
    @(negedge clk);
    check("held_leave", {31'd0, halt}, 32'd0);
    check("held_addr", {27'd0, mem_addr}, 32'd1);
    resume = 1'b0;
    wait_halt(cyc);
    check("held_ret", {16'd0, retired}, 32'd2);

    // rst during a 5-wait read of addr 11 abandons it and restarts at 0.
    clear_prog();
    prog[0] = 8'hAA; prog[1] = 8'hAB; prog[10] = 8'h0F; prog[11] = 8'h03;
    delay = 5;
    do_reset();
    c = 0;
    while (!(mem_req && !mem_we && mem_addr == 5'd11) && c < 200) begin
      @(negedge clk);
      c++;
    end
    check("read11_seen", {27'd0, mem_addr}, 32'd11);
    repeat (2) @(negedge clk);
    check("pre_rst_zero", {31'd0, zero}, 32'd0);
    check("pre_rst_ret", {16'd0, retired}, 32'd1);
    rst   = 1'b1;
    delay = 0;
    @(negedge clk);
    check("abort_req", {31'd0, mem_req}, 32'd0);
    check("abort_zero", {31'd0, zero}, 32'd1);
    check("abort_ret", {16'd0, retired}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("restart_req", {31'd0, mem_req}, 32'd1);
    check("restart_addr", {27'd0, mem_addr}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
